// File: rtl/request_encoder_pkg.sv
// Shared helpers for request_encoder: index-width function and round-robin pointer reset value.
package request_encoder_pkg;

    // All-ones once cast to the pointer width, i.e. IN_WIDTH-1, so the first search starts at index 0.
    localparam int RR_PTR_RESET = -1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_select.sv
// Combinational selector: first set bit of mask found by searching upward from base, wrapping.
// N must be a power of two so the index arithmetic wraps on its own.
module prio_select
    import request_encoder_pkg::*;
#(
    parameter int N = 8,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] base,
    output logic [IW-1:0] index,
    output logic          found
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        index = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && mask[base + IW'(k)]) begin
                index = base + IW'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// Registered request encoder: records requests into a pending set and issues one index per handshake.
// Define REQUEST_ENCODER_RR_EN for round-robin selection; default is fixed lowest-index priority.
module request_encoder
    import request_encoder_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int ACTIVE_HIGH = 0,
    localparam int IN_WIDTH   = 1 << WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_WIDTH-1:0] req,
    input  logic                enable,
    output logic [WIDTH-1:0]    out,
    output logic                valid,
    input  logic                ready,
    output logic [IN_WIDTH-1:0] pending,
    output logic                overrun
);

    logic [IN_WIDTH-1:0] hit;
    logic [IN_WIDTH-1:0] new_req;
    logic [IN_WIDTH-1:0] stalled;
    logic [IN_WIDTH-1:0] claim;
    logic [IN_WIDTH-1:0] pending_next;
    logic [WIDTH-1:0]    base;
    logic [WIDTH-1:0]    sel_index;
    logic [WIDTH-1:0]    out_next;
    logic                found;
    logic                slot_free;
    logic                valid_next;
    logic                overrun_next;

`ifdef REQUEST_ENCODER_RR_EN
    logic [WIDTH-1:0] rr_ptr;

    assign base = rr_ptr + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= WIDTH'(RR_PTR_RESET);
        end else if (slot_free && found) begin
            rr_ptr <= sel_index;
        end
    end
`else
    assign base = '0;
`endif

    prio_select #(.N(IN_WIDTH)) u_prio_select (
        .mask  (pending),
        .base  (base),
        .index (sel_index),
        .found (found)
    );

    always_comb begin
        hit        = (ACTIVE_HIGH != 0) ? req : ~req;
        new_req    = enable ? hit : '0;
        slot_free  = !valid || ready;
        stalled    = (valid && !ready) ? (IN_WIDTH'(1) << out) : '0;
        claim      = '0;
        out_next   = out;
        valid_next = valid;
        if (slot_free) begin
            valid_next = found;
            if (found) begin
                out_next = sel_index;
                claim    = IN_WIDTH'(1) << sel_index;
            end
        end
        overrun_next = |(new_req & (pending | stalled));
        // A repeat of the index held on a stalled output merges into it rather than queueing again.
        pending_next = (pending & ~claim) | (new_req & ~stalled);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading the pre-edge values.
        if (!rst_n) begin
            pending <= '0;
            out     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            pending <= pending_next;
            out     <= out_next;
            valid   <= valid_next;
            overrun <= overrun_next;
        end
    end

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder: an active-high and an active-low instance see the same
// logical requests and are compared every cycle against a set-based reference model.
module tb_request_encoder;

    localparam int WIDTH = 3;
    localparam int N     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             ready = 1'b1;
    logic [N-1:0]     req_hi = '0;
    logic [N-1:0]     req_lo;
    logic [WIDTH-1:0] out_hi, out_lo;
    logic             valid_hi, valid_lo;
    logic [N-1:0]     pending_hi, pending_lo;
    logic             overrun_hi, overrun_lo;

    assign req_lo = ~req_hi;

    request_encoder #(.WIDTH(WIDTH), .ACTIVE_HIGH(1)) u_hi (
        .clk(clk), .rst_n(rst_n), .req(req_hi), .enable(enable), .out(out_hi),
        .valid(valid_hi), .ready(ready), .pending(pending_hi), .overrun(overrun_hi)
    );

    request_encoder #(.WIDTH(WIDTH), .ACTIVE_HIGH(0)) u_lo (
        .clk(clk), .rst_n(rst_n), .req(req_lo), .enable(enable), .out(out_lo),
        .valid(valid_lo), .ready(ready), .pending(pending_lo), .overrun(overrun_lo)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit [N-1:0] m_pend  = '0;
    int         m_out   = 0;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    int         m_ptr   = N - 1;

    int n_checks = 0;
    int n_fail   = 0;
    int issued[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit [N-1:0] nw, stall, claim;
        int start, idx;
        if (!rst_n) begin
            m_pend = '0; m_out = 0; m_valid = 1'b0; m_ovr = 1'b0; m_ptr = N - 1;
            return;
        end
        nw    = enable ? req_hi : '0;
        stall = '0;
        claim = '0;
        if (m_valid && !ready) stall[m_out] = 1'b1;
        m_ovr = |(nw & (m_pend | stall));
        if (!m_valid || ready) begin
`ifdef REQUEST_ENCODER_RR_EN
            start = (m_ptr + 1) % N;
`else
            start = 0;
`endif
            idx = -1;
            for (int k = 0; k < N; k++) begin
                if (idx < 0 && m_pend[(start + k) % N]) idx = (start + k) % N;
            end
            if (idx >= 0) begin
                claim[idx] = 1'b1;
                m_out      = idx;
                m_valid    = 1'b1;
                m_ptr      = idx;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_pend = (m_pend & ~claim) | (nw & ~stall);
    endtask

    task automatic compare_all();
        chk("out_hi",     32'(out_hi),     32'(m_out));
        chk("valid_hi",   32'(valid_hi),   32'(m_valid));
        chk("pending_hi", 32'(pending_hi), 32'(m_pend));
        chk("overrun_hi", 32'(overrun_hi), 32'(m_ovr));
        chk("out_lo",     32'(out_lo),     32'(m_out));
        chk("valid_lo",   32'(valid_lo),   32'(m_valid));
        chk("pending_lo", 32'(pending_lo), 32'(m_pend));
        chk("overrun_lo", 32'(overrun_lo), 32'(m_ovr));
    endtask

    // One clock: note handshakes, advance model at the edge, compare on the falling edge.
    task automatic tick();
        if (rst_n && valid_hi && ready) issued[out_hi]++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        req_hi = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0; ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(valid_hi), 32'd0);
        chk("rst_pending", 32'(pending_hi), 32'd0);
        rst_n = 1'b1;

        // Basic: single request, two-cycle latency.
        enable = 1'b1; ready = 1'b1; req_hi = 8'h10;
        tick();
        req_hi = '0;
        tick();
        chk("basic_out", 32'(out_hi), 32'd4);
        chk("basic_valid", 32'(valid_hi), 32'd1);
        tick();
        chk("basic_valid_drop", 32'(valid_hi), 32'd0);
        chk("basic_pending", 32'(pending_hi), 32'd0);

        // Burst: three requests drain back to back.
        do_reset();
        enable = 1'b1; ready = 1'b1; req_hi = 8'h85;
        tick();
        req_hi = '0;
        tick();
        chk("burst_0", 32'(out_hi), 32'd0);
        tick();
        chk("burst_1", 32'(out_hi), 32'd2);
        chk("burst_1_valid", 32'(valid_hi), 32'd1);
        tick();
        chk("burst_2", 32'(out_hi), 32'd7);
        tick();
        chk("burst_end", 32'(valid_hi), 32'd0);

        // Stall and overrun on the presented index.
        do_reset();
        for (int i = 0; i < N; i++) issued[i] = 0;
        enable = 1'b1; ready = 1'b0; req_hi = 8'h02;
        tick();
        req_hi = '0;
        tick();
        req_hi = 8'h02;
        tick();
        chk("stall_overrun", 32'(overrun_hi), 32'd1);
        chk("stall_out", 32'(out_hi), 32'd1);
        req_hi = '0;
        tick();
        chk("stall_overrun_pulse", 32'(overrun_hi), 32'd0);
        chk("stall_hold", 32'(out_hi), 32'd1);
        ready = 1'b1;
        tick();
        tick();
        tick();
        chk("stall_issue_once", 32'(issued[1]), 32'd1);

        // Polarity and reset behaviour on the active-low instance.
        do_reset();
        enable = 1'b1; ready = 1'b1; req_hi = 8'h01;
        tick();
        req_hi = '0;
        tick();
        chk("lo_out", 32'(out_lo), 32'd0);
        chk("lo_valid", 32'(valid_lo), 32'd1);
        rst_n = 1'b0; req_hi = 8'h01;
        tick();
        chk("lo_rst_valid", 32'(valid_lo), 32'd0);
        chk("lo_rst_pending", 32'(pending_lo), 32'd0);
        rst_n = 1'b1; enable = 1'b0; req_hi = 8'hFF;
        tick();
        tick();
        chk("lo_disabled_valid", 32'(valid_lo), 32'd0);
        chk("lo_disabled_pending", 32'(pending_lo), 32'd0);

`ifdef REQUEST_ENCODER_RR_EN
        // Round-robin alternation with a continuously held pair.
        do_reset();
        enable = 1'b1; ready = 1'b1; req_hi = 8'h03;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_alternate", 32'(out_hi), 32'(k % 2));
        end
`endif

        // Randomised traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            req_hi = N'($urandom & $urandom & $urandom);
            enable = ($urandom_range(0, 3) != 0);
            ready  = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
REQUEST_ENCODER -- requirements
Module: request_encoder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 3, giving the binary index width; the request width is IN_WIDTH = 1 << WIDTH.
REQ-002 The module SHALL have parameter ACTIVE_HIGH, default 0: 1 = request bits active-high, 0 = active-low (one-cold).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port req, input, IN_WIDTH bits: request lines, with polarity set by ACTIVE_HIGH.
REQ-006 The module SHALL have port enable, input, 1 bit: 1 = sample req this cycle; 0 = ignore req.
REQ-007 The module SHALL have port out, output, WIDTH bits: the binary index of the presented request.
REQ-008 The module SHALL have port valid, output, 1 bit: out holds an unclaimed index.
REQ-009 The module SHALL have port ready, input, 1 bit: the consumer accepts out when valid && ready.
REQ-010 The module SHALL have port pending, output, IN_WIDTH bits: the registered set of recorded but unissued requests, always active-high.
REQ-011 The module SHALL have port overrun, output, 1 bit: a one-cycle pulse when a sampled request hits a bit already pending or currently presented.

Function
REQ-012 The module SHALL normalise each request bit internally as hit[i] = ACTIVE_HIGH ? req[i] : ~req[i].
REQ-013 The module SHALL compute new = enable ? hit : 0 each cycle, and update pending_next = (pending & ~claim) | new, so a set wins over a same-cycle clear.
REQ-014 The output slot SHALL be free when valid == 0 or valid && ready; when free and pending != 0, the module SHALL select one index, drive it on out with valid = 1 next cycle, and assert that bit in claim.
REQ-015 When the slot is free and pending == 0, the module SHALL deassert valid next cycle; out SHALL hold its last value.
REQ-016 Latency SHALL be 2 cycles: a req sampled at edge t is in pending after t, and out/valid is updated after edge t+1, provided the slot is free.
REQ-017 With valid && ready held at 1 and pending non-empty, the module SHALL issue one index per cycle with no bubble.
REQ-018 While valid && !ready, out and valid SHALL hold stable and no claim SHALL occur.
REQ-019 The default selection SHALL be fixed priority: the lowest set index of pending wins.
REQ-020 The module SHALL pulse overrun for one cycle when new[i] && (pending[i] || (valid && out == i && !ready)); the duplicate request SHALL be merged, not queued.
REQ-021 enable = 0 SHALL stop only the recording of new requests; draining of pending SHALL continue.

Reset
REQ-022 When rst_n = 0 at a clk edge, the module SHALL clear pending, valid, out and overrun to 0 and reset the round-robin pointer to IN_WIDTH-1, discarding any in-flight index.
REQ-023 The req input SHALL be ignored in a reset cycle; sampling SHALL resume on the first edge with rst_n = 1.

Configuration
REQ-024 When macro REQUEST_ENCODER_RR_EN is defined, selection SHALL be round-robin: the search starts at (last issued index + 1) mod IN_WIDTH and wraps, and the pointer updates on each claim.
REQ-025 When REQUEST_ENCODER_RR_EN is undefined, selection SHALL be the fixed lowest-index priority of REQ-019, and no pointer register SHALL exist.

Structure
REQ-026 A shared package SHALL hold function clog2 and localparam RR_PTR_RESET; no typedefs are needed.
REQ-027 A single sub-module, prio_select (mask in, base pointer in, index out, found out), SHALL perform the combinational selection; under fixed priority its base SHALL be tied to 0.

Verification (WIDTH=3, ACTIVE_HIGH=1 unless noted)
REQ-028 Basic test: with ready=1, req=8'h10 for one cycle -> out=4, valid=1 exactly 2 cycles later for 1 cycle, then pending=0.
REQ-029 Burst test: with ready=1, req=8'h85 for one cycle -> out=0,2,7 on consecutive cycles (fixed) with no gap, then valid=0.
REQ-030 Stall and overrun test: with ready=0 and 8'h02 presented, reassert req=8'h02 -> overrun pulses 1 cycle and out stays 1; after ready=1, index 1 issues exactly once.
REQ-031 Round-robin test with REQUEST_ENCODER_RR_EN: hold req=8'h03 continuously with ready=1 -> out alternates 0,1,0,1.
REQ-032 Polarity and reset test: with ACTIVE_HIGH=0, req=8'hFE, enable=1 -> out=0; rst_n=0 while valid -> next cycle valid=0 and pending=0; enable=0 with req active -> nothing issued.
